// File: rtl/siwo_fetch_queue.sv
// siwo_fetch_queue: decoupled instruction fetch unit with PC, prefetch queue,
// absolute/PC-relative redirect, sticky halt and retired-instruction counter.
// Optional build macro: SIWO_FETCH_BYPASS_EN -- when the queue is empty, a
// response arriving this cycle is shown directly on the head outputs.
module siwo_fetch_queue #(
    parameter int INSN_WIDTH = 9,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  run_i,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic [INSN_WIDTH-1:0] imem_data_i,
    output logic                  valid_o,
    output logic [INSN_WIDTH-1:0] instruction_o,
    output logic [ADDR_WIDTH-1:0] insn_addr_o,
    input  logic                  ready_i,
    input  logic                  redirect_i,
    input  logic                  relative_i,
    input  logic [ADDR_WIDTH-1:0] target_i,
    input  logic                  halt_i,
    output logic                  halted_o,
    output logic [CNT_WIDTH-1:0]  insn_count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);

    logic [INSN_WIDTH-1:0] insn_mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_mem_q [DEPTH];

    logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] inflight_addr_q, inflight_addr_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  halted_q, halted_d;
    logic [CNT_WIDTH-1:0]  insn_count_q, insn_count_d;

    logic                  queue_empty;
    logic                  bypass;
    logic                  consume;
    logic                  flush;
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic [CNT_W:0]        occupancy;
    logic [INSN_WIDTH-1:0] head_insn;
    logic [ADDR_WIDTH-1:0] head_addr;

    // Head selection, handshake decode and request issue.
    always_comb begin
        queue_empty = (count_q == '0);
`ifdef SIWO_FETCH_BYPASS_EN
        bypass = queue_empty && inflight_q;
`else
        bypass = 1'b0;
`endif
        head_insn = bypass ? imem_data_i     : insn_mem_q[head_q];
        head_addr = bypass ? inflight_addr_q : addr_mem_q[head_q];

        valid_o       = !halted_q && (!queue_empty || bypass);
        instruction_o = valid_o ? head_insn : '0;
        insn_addr_o   = valid_o ? head_addr : '0;

        consume = valid_o && ready_i;
        flush   = consume && (redirect_i || halt_i);
        pop     = consume && !queue_empty;
        // A bypassed response that is consumed on arrival never enters the queue.
        push    = inflight_q && !flush && !(consume && queue_empty);

        occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
        // Reset gates the request so it reads low while rst_ni is held.
        issue = rst_ni && run_i && !halted_q && !flush && (occupancy < DEPTH_L);

        imem_req_o   = issue;
        imem_addr_o  = pc_q;
        halted_o     = halted_q;
        insn_count_o = insn_count_q;
    end

    // Next-state for pointers, occupancy, PC, halt and counter.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PTR_W'(1);
            if (pop)  head_d = head_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end

        pc_d = pc_q;
        if (consume && redirect_i && !halt_i)
            pc_d = relative_i ? (head_addr + target_i) : target_i;
        else if (issue)
            pc_d = pc_q + ADDR_WIDTH'(1);

        inflight_d      = issue;
        inflight_addr_d = pc_q;
        halted_d        = halted_q || (consume && halt_i);
        insn_count_d    = consume ? (insn_count_q + CNT_WIDTH'(1)) : insn_count_q;
    end

    // Control state registers; reset discards all queued and in-flight work.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            pc_q            <= RESET_PC;
            halted_q        <= 1'b0;
            insn_count_q    <= '0;
        end else begin
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
            pc_q            <= pc_d;
            halted_q        <= halted_d;
            insn_count_q    <= insn_count_d;
        end
    end

    // Queue storage; contents are only observed through count_q so no reset needed.
    always_ff @(posedge clk_i) begin
        if (push) begin
            insn_mem_q[tail_q] <= imem_data_i;
            addr_mem_q[tail_q] <= inflight_addr_q;
        end
    end

endmodule

// File: tb/tb_siwo_fetch_queue.sv
// Testbench for siwo_fetch_queue: queue-level reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_siwo_fetch_queue;

`ifdef SIWO_FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int DEPTH = 4;
    localparam int LAT   = BYP ? 1 : 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [8:0]  imem_data;
    logic        valid;
    logic [8:0]  instruction;
    logic [7:0]  insn_addr;
    logic        ready = 1'b0;
    logic        redirect = 1'b0;
    logic        relative = 1'b0;
    logic [7:0]  target = 8'h00;
    logic        halt = 1'b0;
    logic        halted;
    logic [15:0] insn_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] imem [256];
    logic [7:0] resp_addr = 8'h00;

    siwo_fetch_queue #(
        .INSN_WIDTH(9), .ADDR_WIDTH(8), .DEPTH(DEPTH), .CNT_WIDTH(16), .RESET_PC(8'h00)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .run_i(run),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_data_i(imem_data),
        .valid_o(valid), .instruction_o(instruction), .insn_addr_o(insn_addr),
        .ready_i(ready), .redirect_i(redirect), .relative_i(relative), .target_i(target),
        .halt_i(halt), .halted_o(halted), .insn_count_o(insn_count)
    );

    always #5 clk = ~clk;

    // Instruction memory: data for the address requested last cycle.
    always @(posedge clk) if (imem_req) resp_addr <= imem_addr;
    assign imem_data = imem[resp_addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (queue level) ----------------
    typedef struct packed {
        logic [8:0] insn;
        logic [7:0] addr;
    } ent_t;

    ent_t        mq[$];
    logic [7:0]  m_pc = 8'h00;
    bit          m_inf = 1'b0;
    logic [7:0]  m_inf_addr = 8'h00;
    bit          m_halted = 1'b0;
    logic [15:0] m_cnt = 16'h0;
    bit          m_valid, m_cons, m_flush, m_req;
    logic [8:0]  m_insn;
    logic [7:0]  m_addr;
    ent_t        m_resp;
    bit          m_was_empty;
    logic [7:0]  m_old_pc;

    task automatic m_eval();
        m_valid = !m_halted && (mq.size() != 0 || (BYP && m_inf));
        if (mq.size() != 0) begin
            m_insn = mq[0].insn;
            m_addr = mq[0].addr;
        end else begin
            m_insn = imem[m_inf_addr];
            m_addr = m_inf_addr;
        end
        m_cons  = m_valid && ready;
        m_flush = m_cons && (halt || redirect);
        m_req   = run && !m_halted && !m_flush && (mq.size() + int'(m_inf) < DEPTH);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_pc = 8'h00; m_inf = 1'b0; m_inf_addr = 8'h00;
            m_halted = 1'b0; m_cnt = 16'h0;
        end else begin
            m_eval();
            m_was_empty = (mq.size() == 0);
            m_old_pc    = m_pc;
            m_resp.insn = imem[m_inf_addr];
            m_resp.addr = m_inf_addr;
            if (m_flush) mq.delete();
            else begin
                if (m_cons && !m_was_empty) void'(mq.pop_front());
                if (m_inf && !(m_cons && m_was_empty)) mq.push_back(m_resp);
            end
            if (m_cons) m_cnt = m_cnt + 16'd1;
            if (m_cons && halt) m_halted = 1'b1;
            if (m_cons && redirect && !halt) m_pc = relative ? 8'(m_addr + target) : target;
            else if (m_req) m_pc = m_old_pc + 8'd1;
            m_inf      = m_req;
            m_inf_addr = m_old_pc;
        end
    end

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_req",   32'(imem_req),    32'd0);
            chk("rst_valid", 32'(valid),       32'd0);
            chk("rst_insn",  32'(instruction), 32'd0);
            chk("rst_iaddr", 32'(insn_addr),   32'd0);
            chk("rst_halt",  32'(halted),      32'd0);
            chk("rst_count", 32'(insn_count),  32'd0);
        end else begin
            m_eval();
            chk("m_req",   32'(imem_req), 32'(m_req));
            if (m_req) chk("m_addr", 32'(imem_addr), 32'(m_pc));
            chk("m_valid", 32'(valid), 32'(m_valid));
            if (m_valid) begin
                chk("m_insn",  32'(instruction), 32'(m_insn));
                chk("m_iaddr", 32'(insn_addr),   32'(m_addr));
            end
            chk("m_halted", 32'(halted),     32'(m_halted));
            chk("m_count",  32'(insn_count), 32'(m_cnt));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b0; ready = 1'b0; redirect = 1'b0;
        relative = 1'b0; target = 8'h00; halt = 1'b0;
        step();
        step();
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_req",   32'(imem_req), 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic wait_head(input bit match_addr, input logic [7:0] a, input string nm);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 24; k++) begin
            if (valid && (!match_addr || insn_addr == a)) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk(nm, 32'(ok), 32'd1);
    endtask

    task automatic do_redirect(input bit rel, input logic [7:0] tgt);
        redirect = 1'b1; relative = rel; target = tgt;
        #1;
        chk("redir_same_cycle_req", 32'(imem_req), 32'd0);
        step();
        redirect = 1'b0; relative = 1'b0; target = 8'h00;
        #1;
    endtask

    initial begin
        int nreq;
        for (int i = 0; i < 256; i++) imem[i] = 9'(i + 16);

        // 1: streaming after reset
        do_reset();
        run = 1'b1; ready = 1'b1;
        #1;
        chk("t1_first_req",  32'(imem_req),  32'd1);
        chk("t1_first_addr", 32'(imem_addr), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("t1_valid", 32'(valid), 32'(k >= LAT));
            if (k >= LAT) begin
                chk("t1_insn",  32'(instruction), 32'(16 + k - LAT));
                chk("t1_iaddr", 32'(insn_addr),   32'(k - LAT));
                chk("t1_count", 32'(insn_count),  32'(k - LAT));
            end
        end

        // 2: fill with decode stalled, then drain in order
        do_reset();
        run = 1'b1; ready = 1'b0;
        nreq = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (imem_req) begin
                chk("t2_req_addr", 32'(imem_addr), 32'(nreq));
                nreq++;
            end
            step();
        end
        chk("t2_nreq", 32'(nreq), 32'(DEPTH));
        chk("t2_full_noreq", 32'(imem_req), 32'd0);
        ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            chk("t2_pop_valid", 32'(valid),       32'd1);
            chk("t2_pop_insn",  32'(instruction), 32'(16 + j));
            chk("t2_pop_addr",  32'(insn_addr),   32'(j));
            step();
        end

        // 3: relative and absolute redirects
        do_reset();
        run = 1'b1; ready = 1'b1;
        wait_head(1'b1, 8'h05, "t3_wait_05");
        do_redirect(1'b1, 8'hFD);
        chk("t3_rel_req",  32'(imem_req),  32'd1);
        chk("t3_rel_addr", 32'(imem_addr), 32'h02);
        for (int k = 1; k <= LAT + 1; k++) begin
            chk("t3_penalty_valid", 32'(valid), 32'(k == LAT + 1));
            if (k < LAT + 1) step();
        end
        chk("t3_target_addr", 32'(insn_addr),   32'h02);
        chk("t3_target_insn", 32'(instruction), 32'h12);
        wait_head(1'b0, 8'h00, "t3_wait_any");
        do_redirect(1'b0, 8'h40);
        chk("t3_abs_addr", 32'(imem_addr), 32'h40);

        // 4: PC wrap and relative wrap
        wait_head(1'b0, 8'h00, "t4_wait_any");
        do_redirect(1'b0, 8'hFE);
        chk("t4_addr_fe", 32'(imem_addr), 32'hFE);
        step();
        chk("t4_addr_ff", 32'(imem_addr), 32'hFF);
        step();
        chk("t4_addr_00", 32'(imem_addr), 32'h00);
        wait_head(1'b1, 8'hFF, "t4_wait_ff");
        chk("t4_insn_ff", 32'(instruction), 32'h10F);
        do_redirect(1'b1, 8'h03);
        chk("t4_wrap_req",  32'(imem_req),  32'd1);
        chk("t4_wrap_addr", 32'(imem_addr), 32'h02);

        // 5: halt beats redirect, sticky until reset
        wait_head(1'b0, 8'h00, "t5_wait_any");
        halt = 1'b1; redirect = 1'b1; target = 8'h80;
        #1;
        chk("t5_same_cycle_req", 32'(imem_req), 32'd0);
        step();
        halt = 1'b0; redirect = 1'b0; target = 8'h00;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("t5_halted", 32'(halted),   32'd1);
            chk("t5_valid",  32'(valid),    32'd0);
            chk("t5_req",    32'(imem_req), 32'd0);
            step();
        end
        rst_n = 1'b0;
        #1;
        chk("t5_rst_halted", 32'(halted), 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("t5_restart_req",  32'(imem_req),  32'd1);
        chk("t5_restart_addr", 32'(imem_addr), 32'd0);

        // 6: async reset with a request in flight
        step(); step(); step();
        chk("t6_pre_req", 32'(imem_req), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 32'(valid),       32'd0);
        chk("t6_async_req",   32'(imem_req),    32'd0);
        chk("t6_async_insn",  32'(instruction), 32'd0);
        chk("t6_async_iaddr", 32'(insn_addr),   32'd0);
        chk("t6_async_count", 32'(insn_count),  32'd0);
        run = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t6_post_valid", 32'(valid),    32'd0);
            chk("t6_post_req",   32'(imem_req), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
